// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the SPI frame arbiter.
//   - State encodings and the FSM state type.
//   - Default frame width.
//   - rr_pick(): round-robin winner search, upward from a pointer with wrap.
package spi_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_SHIFT = SHIFT,
    ST_GAP   = GAP
  } state_t;

  localparam int DEF_FRAME_W = 60;
  localparam int MAX_REQ     = 8;

  // Returns the first set bit of req[n-1:0], starting at ptr and wrapping at n.
  // Callers only use the result when req is nonzero.
  function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                         input logic [2:0]         ptr,
                                         input int                 n);
    logic [2:0] win;
    logic       found;
    int         idx;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      idx = (int'(ptr) + i) % n;
      if (!found && (i < n) && req[idx]) begin
        win   = 3'(idx);
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/spi_frame_shifter.sv
// spi_frame_shifter: serialises one latched frame MSB-first onto SPI_SDI with
// chip select low. All state updates on the falling clock edge.
// Ports:
//   clk       in   serial clock (falling-edge active)
//   reset     in   synchronous, active-high
//   load      in   latch frame, drive its MSB and pull csb low
//   frame     in   FRAME_W-bit frame to send
//   csb       out  chip select, active low
//   sdi       out  serial data; holds its last value while csb is high
//   last_bit  out  high while the LSB is on the wire (frame ends on next edge)
module spi_frame_shifter
  import spi_pkg::*;
#(
  parameter int FRAME_W = DEF_FRAME_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [FRAME_W-1:0] frame,
  output logic               csb,
  output logic               sdi,
  output logic               last_bit
);

  localparam int CNT_W = $clog2(FRAME_W);

  logic [FRAME_W-1:0] shift_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               csb_reg;
  logic               sdi_reg;

  // shift_reg always holds the next bit to send in its MSB, so the bit put on
  // the wire on each edge is frame[cnt-1] without a wide mux.
  always_ff @(negedge clk) begin
    if (reset) begin
      shift_reg <= '0;
      cnt_reg   <= '0;
      csb_reg   <= 1'b1;
      sdi_reg   <= 1'b0;
    end else if (load) begin
      shift_reg <= {frame[FRAME_W-2:0], 1'b0};
      sdi_reg   <= frame[FRAME_W-1];
      cnt_reg   <= CNT_W'(FRAME_W - 1);
      csb_reg   <= 1'b0;
    end else if (!csb_reg) begin
      if (cnt_reg != '0) begin
        sdi_reg   <= shift_reg[FRAME_W-1];
        shift_reg <= {shift_reg[FRAME_W-2:0], 1'b0};
        cnt_reg   <= cnt_reg - 1'b1;
      end else begin
        // LSB has been held for a full cycle; deselect but keep SDI on the LSB.
        csb_reg <= 1'b1;
      end
    end
  end

  assign csb      = csb_reg;
  assign sdi      = sdi_reg;
  assign last_bit = !csb_reg && (cnt_reg == '0);

endmodule

// File: rtl/spi_frame_arbiter.sv
// spi_frame_arbiter: shares one SPI link between NUM_REQ frame requesters.
// A round-robin winner is chosen only while idle; its frame is latched and
// shifted MSB-first by spi_frame_shifter. All registers update on the falling
// edge of SPI_CLK so the slave can sample SDI on the rising edge.
// Optional build macro: SPI_ARB_GAP_EN adds a GAP state holding CSB high for
// GAP_CYCLES extra cycles between frames (default build: 1-cycle deselect).
// Ports:
//   SPI_CLK   in   the only clock
//   reset     in   synchronous, active-high; aborts any frame in flight
//   req       in   level request per requester, held until gnt
//   req_data  in   requester i's frame at [i*FRAME_W +: FRAME_W]
//   gnt       out  one-hot pulse on the cycle the frame is latched
//   done      out  one-hot pulse when the winner's frame has completed
//   busy      out  high from the grant edge until the done edge
//   grant_id  out  index of the current or last winner
//   SPI_CSB   out  chip select, active low
//   SPI_SDI   out  serial data, MSB first
module spi_frame_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int FRAME_W    = DEF_FRAME_W,
  parameter int GAP_CYCLES = 4
) (
  input  logic                       SPI_CLK,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*FRAME_W-1:0] req_data,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         done,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       SPI_CSB,
  output logic                       SPI_SDI
);

  localparam int ID_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || GAP_CYCLES < 1 || GAP_CYCLES > 15) begin : g_param_check
    $error("spi_frame_arbiter: NUM_REQ must be 2..8 and GAP_CYCLES 1..15");
  end

  state_t              state_reg, state_next;
  logic [ID_W-1:0]     rr_ptr_reg, rr_ptr_next;
  logic [ID_W-1:0]     grant_id_reg, grant_id_next;
  logic [NUM_REQ-1:0]  gnt_reg, gnt_next;
  logic [NUM_REQ-1:0]  done_reg, done_next;
  logic                busy_reg, busy_next;
  logic                load;
  logic                last_bit;
`ifdef SPI_ARB_GAP_EN
  logic [3:0]          gap_cnt_reg, gap_cnt_next;
`endif

  // Split the flat request bus into one frame per requester.
  logic [FRAME_W-1:0]  frames [NUM_REQ];
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_frame
    assign frames[gi] = req_data[gi*FRAME_W +: FRAME_W];
  end

  logic [MAX_REQ-1:0]  req_ext;
  logic [ID_W-1:0]     winner;
  logic [FRAME_W-1:0]  frame_sel;

  always_comb begin
    req_ext              = '0;
    req_ext[NUM_REQ-1:0] = req;
  end

  assign winner    = ID_W'(rr_pick(req_ext, 3'(rr_ptr_reg), NUM_REQ));
  assign frame_sel = frames[winner];

  always_comb begin
    state_next    = state_reg;
    rr_ptr_next   = rr_ptr_reg;
    grant_id_next = grant_id_reg;
    gnt_next      = '0;
    done_next     = '0;
    busy_next     = busy_reg;
    load          = 1'b0;
`ifdef SPI_ARB_GAP_EN
    gap_cnt_next  = gap_cnt_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (|req) begin
          load             = 1'b1;
          gnt_next[winner] = 1'b1;
          grant_id_next    = winner;
          busy_next        = 1'b1;
          state_next       = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (last_bit) begin
          done_next[grant_id_reg] = 1'b1;
          busy_next               = 1'b0;
          // Moving the pointer past the winner gives every other pending
          // requester priority over a requester that keeps req high.
          rr_ptr_next = (grant_id_reg == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_reg + 1'b1;
`ifdef SPI_ARB_GAP_EN
          gap_cnt_next = '0;
          state_next   = ST_GAP;
`else
          state_next   = ST_IDLE;
`endif
        end
      end
`ifdef SPI_ARB_GAP_EN
      ST_GAP: begin
        if (gap_cnt_reg == 4'(GAP_CYCLES - 1)) begin
          state_next = ST_IDLE;
        end else begin
          gap_cnt_next = gap_cnt_reg + 1'b1;
        end
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(negedge SPI_CLK) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      rr_ptr_reg   <= '0;
      grant_id_reg <= '0;
      gnt_reg      <= '0;
      done_reg     <= '0;
      busy_reg     <= 1'b0;
`ifdef SPI_ARB_GAP_EN
      gap_cnt_reg  <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      rr_ptr_reg   <= rr_ptr_next;
      grant_id_reg <= grant_id_next;
      gnt_reg      <= gnt_next;
      done_reg     <= done_next;
      busy_reg     <= busy_next;
`ifdef SPI_ARB_GAP_EN
      gap_cnt_reg  <= gap_cnt_next;
`endif
    end
  end

  spi_frame_shifter #(
    .FRAME_W (FRAME_W)
  ) u_shifter (
    .clk      (SPI_CLK),
    .reset    (reset),
    .load     (load),
    .frame    (frame_sel),
    .csb      (SPI_CSB),
    .sdi      (SPI_SDI),
    .last_bit (last_bit)
  );

  assign gnt      = gnt_reg;
  assign done     = done_reg;
  assign busy     = busy_reg;
  assign grant_id = grant_id_reg;

endmodule

// File: tb/tb_spi_frame_arbiter.sv
// Bench for spi_frame_arbiter: scenario tasks with a scoreboard queue of
// expected (requester, frame) pairs. SDI is captured while CSB is low and
// compared at each done pulse.
module tb_spi_frame_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int FRAME_W    = 60;
  localparam int GAP_CYCLES = 4;
  localparam int ID_W       = 2;
`ifdef SPI_ARB_GAP_EN
  localparam int EXP_DESEL  = 1 + GAP_CYCLES;
`else
  localparam int EXP_DESEL  = 1;
`endif

  logic                       SPI_CLK = 1'b0;
  logic                       reset;
  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ*FRAME_W-1:0] req_data;
  logic [NUM_REQ-1:0]         gnt;
  logic [NUM_REQ-1:0]         done;
  logic                       busy;
  logic [ID_W-1:0]            grant_id;
  logic                       SPI_CSB;
  logic                       SPI_SDI;

  spi_frame_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .FRAME_W    (FRAME_W),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .SPI_CLK  (SPI_CLK),
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .done     (done),
    .busy     (busy),
    .grant_id (grant_id),
    .SPI_CSB  (SPI_CSB),
    .SPI_SDI  (SPI_SDI)
  );

  always #5 SPI_CLK = ~SPI_CLK;

  typedef struct {
    int                 id;
    logic [FRAME_W-1:0] frame;
  } exp_t;

  exp_t               exp_q[$];
  int                 n_checks = 0;
  int                 n_fails  = 0;
  int                 cyc      = 0;
  int                 gnt_cyc  = 0;
  int                 done_cyc = 0;
  int                 cap_len  = 0;
  logic [FRAME_W-1:0] cap_frame = '0;

  // One clock: wait for the rising edge (DUT updates on the falling edge) and
  // record what the link shows. Inputs are changed by callers right after.
  task automatic cycle();
    @(posedge SPI_CLK);
    cyc++;
    if (|gnt) begin
      gnt_cyc   = cyc;
      cap_frame = '0;
      cap_len   = 0;
    end
    if (SPI_CSB === 1'b0) begin
      cap_frame = {cap_frame[FRAME_W-2:0], SPI_SDI};
      cap_len++;
    end
    if (|done) done_cyc = cyc;
  endtask

  task automatic wait_gnt();
    for (int i = 0; i < 300; i++) begin
      cycle();
      if (|gnt) break;
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300; i++) begin
      cycle();
      if (|done) break;
    end
  endtask

  task automatic set_frame(input int i, input logic [FRAME_W-1:0] f);
    req_data[i*FRAME_W +: FRAME_W] = f;
  endtask

  function automatic logic [FRAME_W-1:0] rnd_frame();
    return FRAME_W'({$urandom(), $urandom()});
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = '0;
    req_data = '0;
    repeat (3) cycle();
    n_checks++;
    if (SPI_CSB !== 1'b1 || SPI_SDI !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_link: csb=%b sdi=%b, expected csb=1 sdi=0", SPI_CSB, SPI_SDI);
    end
    n_checks++;
    if (gnt !== '0 || done !== '0 || busy !== 1'b0 || grant_id !== '0) begin
      n_fails++;
      $display("FAIL reset_ctrl: gnt=%b done=%b busy=%b id=%0d, expected all 0", gnt, done, busy, grant_id);
    end
    reset = 1'b0;
    cycle();
    n_checks++;
    if (gnt !== '0 || SPI_CSB !== 1'b1 || busy !== 1'b0) begin
      n_fails++;
      $display("FAIL idle_no_req: gnt=%b csb=%b busy=%b, expected 0 1 0", gnt, SPI_CSB, busy);
    end
    $display("reset: csb=%b sdi=%b busy=%b", SPI_CSB, SPI_SDI, busy);
  endtask

  task automatic test_single();
    exp_t e;
    logic [FRAME_W-1:0] f;
    f = 60'hAA5_123456789ABC;
    set_frame(0, f);
    exp_q.push_back('{id: 0, frame: f});
    req = 4'b0001;
    cycle();
    n_checks++;
    if (gnt !== 4'b0001 || SPI_CSB !== 1'b0 || busy !== 1'b1 || grant_id !== 2'd0 || SPI_SDI !== f[FRAME_W-1]) begin
      n_fails++;
      $display("FAIL single_grant: gnt=%b csb=%b busy=%b id=%0d sdi=%b, expected 0001 0 1 0 %b",
               gnt, SPI_CSB, busy, grant_id, SPI_SDI, f[FRAME_W-1]);
    end
    req = '0;
    wait_done();
    e = exp_q.pop_front();
    n_checks++;
    if (done !== 4'b0001 || done_cyc - gnt_cyc != FRAME_W) begin
      n_fails++;
      $display("FAIL single_done: done=%b after %0d cycles, expected 0001 after %0d", done, done_cyc - gnt_cyc, FRAME_W);
    end
    n_checks++;
    if (cap_frame !== e.frame || cap_len != FRAME_W) begin
      n_fails++;
      $display("FAIL single_frame: got %h (%0d bits), expected %h (%0d bits)", cap_frame, cap_len, e.frame, FRAME_W);
    end
    n_checks++;
    if (SPI_CSB !== 1'b1 || busy !== 1'b0 || SPI_SDI !== e.frame[0]) begin
      n_fails++;
      $display("FAIL single_end: csb=%b busy=%b sdi=%b, expected 1 0 %b", SPI_CSB, busy, SPI_SDI, e.frame[0]);
    end
    $display("frame id=%0d data=%h len=%0d", e.id, cap_frame, cap_len);
    cycle();
    n_checks++;
    if (done !== '0 || SPI_CSB !== 1'b1 || SPI_SDI !== e.frame[0]) begin
      n_fails++;
      $display("FAIL single_hold: done=%b csb=%b sdi=%b, expected 0000 1 %b", done, SPI_CSB, SPI_SDI, e.frame[0]);
    end
  endtask

  task automatic test_all_requesters();
    exp_t e;
    logic [FRAME_W-1:0] fr [NUM_REQ];
    int order [5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      fr[i] = rnd_frame();
      set_frame(i, fr[i]);
    end
    for (int n = 0; n < 5; n++) exp_q.push_back('{id: order[n], frame: fr[order[n]]});
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_gnt();
      if (n == 4) req = '0;
      n_checks++;
      if (gnt !== 4'(1 << exp_q[0].id) || grant_id !== ID_W'(exp_q[0].id)) begin
        n_fails++;
        $display("FAIL all_order%0d: gnt=%b id=%0d, expected id=%0d", n, gnt, grant_id, exp_q[0].id);
      end
      if (n > 0) begin
        n_checks++;
        if (gnt_cyc - done_cyc != EXP_DESEL) begin
          n_fails++;
          $display("FAIL all_deselect%0d: csb high %0d cycles, expected %0d", n, gnt_cyc - done_cyc, EXP_DESEL);
        end
      end
      wait_done();
      e = exp_q.pop_front();
      n_checks++;
      if (done !== 4'(1 << e.id) || cap_frame !== e.frame || cap_len != FRAME_W) begin
        n_fails++;
        $display("FAIL all_frame%0d: done=%b data=%h len=%0d, expected done id=%0d data=%h len=%0d",
                 n, done, cap_frame, cap_len, e.id, e.frame, FRAME_W);
      end
      $display("frame id=%0d data=%h len=%0d", e.id, cap_frame, cap_len);
    end
  endtask

  task automatic test_late_request();
    exp_t e;
    logic [FRAME_W-1:0] fa, fb;
    fa = rnd_frame();
    fb = rnd_frame();
    set_frame(1, fa);
    set_frame(2, fb);
    exp_q.push_back('{id: 1, frame: fa});
    exp_q.push_back('{id: 2, frame: fb});
    req = 4'b0010;
    wait_gnt();
    req = '0;
    n_checks++;
    if (gnt !== 4'b0010) begin
      n_fails++;
      $display("FAIL late_first_gnt: gnt=%b, expected 0010", gnt);
    end
    repeat (20) cycle();
    req[2] = 1'b1;
    wait_done();
    e = exp_q.pop_front();
    n_checks++;
    if (done !== 4'b0010 || cap_frame !== e.frame || cap_len != FRAME_W) begin
      n_fails++;
      $display("FAIL late_inflight: done=%b data=%h len=%0d, expected 0010 %h %0d", done, cap_frame, cap_len, e.frame, FRAME_W);
    end
    $display("frame id=%0d data=%h len=%0d", e.id, cap_frame, cap_len);
    wait_gnt();
    req = '0;
    n_checks++;
    if (gnt !== 4'b0100 || gnt_cyc - done_cyc != EXP_DESEL) begin
      n_fails++;
      $display("FAIL late_grant: gnt=%b %0d cycles after done, expected 0100 after %0d", gnt, gnt_cyc - done_cyc, EXP_DESEL);
    end
    wait_done();
    e = exp_q.pop_front();
    n_checks++;
    if (done !== 4'b0100 || cap_frame !== e.frame || cap_len != FRAME_W) begin
      n_fails++;
      $display("FAIL late_frame: done=%b data=%h len=%0d, expected 0100 %h %0d", done, cap_frame, cap_len, e.frame, FRAME_W);
    end
    $display("frame id=%0d data=%h len=%0d", e.id, cap_frame, cap_len);
  endtask

  task automatic test_abort();
    exp_t e;
    logic [FRAME_W-1:0] fx, f1, f3;
    fx = rnd_frame();
    f1 = rnd_frame();
    f3 = rnd_frame();
    // Pointer is 3 here, so requester 2 is reached after wrapping.
    set_frame(2, fx);
    req = 4'b0100;
    wait_gnt();
    req = '0;
    n_checks++;
    if (gnt !== 4'b0100) begin
      n_fails++;
      $display("FAIL abort_gnt: gnt=%b, expected 0100", gnt);
    end
    repeat (30) cycle();
    reset = 1'b1;
    cycle();
    n_checks++;
    if (SPI_CSB !== 1'b1 || SPI_SDI !== 1'b0 || busy !== 1'b0 || done !== '0) begin
      n_fails++;
      $display("FAIL abort_reset: csb=%b sdi=%b busy=%b done=%b, expected 1 0 0 0000", SPI_CSB, SPI_SDI, busy, done);
    end
    reset = 1'b0;
    cycle();
    n_checks++;
    if (done !== '0 || SPI_CSB !== 1'b1) begin
      n_fails++;
      $display("FAIL abort_nodone: done=%b csb=%b, expected 0000 1", done, SPI_CSB);
    end
    $display("abort: frame from id=2 dropped after %0d bits", cap_len);
    // With the pointer back at 0, requester 1 must beat requester 3.
    set_frame(1, f1);
    set_frame(3, f3);
    exp_q.push_back('{id: 1, frame: f1});
    exp_q.push_back('{id: 3, frame: f3});
    req = 4'b1010;
    for (int n = 0; n < 2; n++) begin
      wait_gnt();
      req[exp_q[0].id] = 1'b0;
      n_checks++;
      if (gnt !== 4'(1 << exp_q[0].id)) begin
        n_fails++;
        $display("FAIL abort_regrant%0d: gnt=%b, expected id=%0d", n, gnt, exp_q[0].id);
      end
      wait_done();
      e = exp_q.pop_front();
      n_checks++;
      if (done !== 4'(1 << e.id) || cap_frame !== e.frame || cap_len != FRAME_W) begin
        n_fails++;
        $display("FAIL abort_frame%0d: done=%b data=%h len=%0d, expected id=%0d %h %0d",
                 n, done, cap_frame, cap_len, e.id, e.frame, FRAME_W);
      end
      $display("frame id=%0d data=%h len=%0d", e.id, cap_frame, cap_len);
    end
  endtask

  task automatic test_withdraw_fairness();
    exp_t e;
    logic [NUM_REQ-1:0] seen;
    logic [FRAME_W-1:0] f0, f1, fa;
    f0 = rnd_frame();
    f1 = rnd_frame();
    fa = rnd_frame();
    set_frame(1, fa);
    set_frame(3, rnd_frame());
    exp_q.push_back('{id: 1, frame: fa});
    req = 4'b0010;
    wait_gnt();
    req = '0;
    repeat (10) cycle();
    req[3] = 1'b1;
    repeat (10) cycle();
    req[3] = 1'b0;
    wait_done();
    e = exp_q.pop_front();
    n_checks++;
    if (done !== 4'b0010 || cap_frame !== e.frame || cap_len != FRAME_W) begin
      n_fails++;
      $display("FAIL withdraw_frame: done=%b data=%h len=%0d, expected 0010 %h %0d", done, cap_frame, cap_len, e.frame, FRAME_W);
    end
    $display("frame id=%0d data=%h len=%0d", e.id, cap_frame, cap_len);
    seen = '0;
    repeat (EXP_DESEL + 6) begin
      cycle();
      seen |= gnt;
    end
    n_checks++;
    if (seen !== '0 || SPI_SDI !== fa[0] || SPI_CSB !== 1'b1) begin
      n_fails++;
      $display("FAIL withdraw_idle: gnt seen=%b sdi=%b csb=%b, expected 0000 %b 1", seen, SPI_SDI, SPI_CSB, fa[0]);
    end
    // Requester 0 keeps req high after its done; requester 1 must go next.
    set_frame(0, f0);
    set_frame(1, f1);
    exp_q.push_back('{id: 0, frame: f0});
    exp_q.push_back('{id: 1, frame: f1});
    exp_q.push_back('{id: 0, frame: f0});
    req = 4'b0001;
    for (int n = 0; n < 3; n++) begin
      wait_gnt();
      if (n == 0) begin
        repeat (5) cycle();
        req[1] = 1'b1;
      end else begin
        req[exp_q[0].id] = 1'b0;
      end
      n_checks++;
      if (grant_id !== ID_W'(exp_q[0].id)) begin
        n_fails++;
        $display("FAIL fair_order%0d: id=%0d, expected %0d", n, grant_id, exp_q[0].id);
      end
      wait_done();
      e = exp_q.pop_front();
      n_checks++;
      if (done !== 4'(1 << e.id) || cap_frame !== e.frame || cap_len != FRAME_W) begin
        n_fails++;
        $display("FAIL fair_frame%0d: done=%b data=%h len=%0d, expected id=%0d %h %0d",
                 n, done, cap_frame, cap_len, e.id, e.frame, FRAME_W);
      end
      $display("frame id=%0d data=%h len=%0d", e.id, cap_frame, cap_len);
    end
  endtask

  task automatic test_patterns();
    exp_t e;
    logic [FRAME_W-1:0] ones, zeros;
    ones  = '1;
    zeros = '0;
    // Pointer is 1 here, so requester 2 (all ones) is served before 3.
    set_frame(2, ones);
    set_frame(3, zeros);
    exp_q.push_back('{id: 2, frame: ones});
    exp_q.push_back('{id: 3, frame: zeros});
    req = 4'b1100;
    for (int n = 0; n < 2; n++) begin
      wait_gnt();
      req[exp_q[0].id] = 1'b0;
      n_checks++;
      if (grant_id !== ID_W'(exp_q[0].id) || SPI_SDI !== exp_q[0].frame[FRAME_W-1]) begin
        n_fails++;
        $display("FAIL pattern_gnt%0d: id=%0d sdi=%b, expected id=%0d sdi=%b",
                 n, grant_id, SPI_SDI, exp_q[0].id, exp_q[0].frame[FRAME_W-1]);
      end
      wait_done();
      e = exp_q.pop_front();
      n_checks++;
      if (cap_frame !== e.frame || cap_len != FRAME_W || SPI_SDI !== e.frame[0]) begin
        n_fails++;
        $display("FAIL pattern_frame%0d: data=%h len=%0d sdi=%b, expected %h %0d %b",
                 n, cap_frame, cap_len, SPI_SDI, e.frame, FRAME_W, e.frame[0]);
      end
      $display("frame id=%0d data=%h len=%0d", e.id, cap_frame, cap_len);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_all_requesters();
    test_late_request();
    test_abort();
    test_withdraw_fairness();
    test_patterns();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/spi_frame_arbiter.md
# spi_frame_arbiter

Shares one SPI serial link (SPI_CSB/SPI_SDI) between NUM_REQ frame requesters. Each requester presents a FRAME_W-bit frame and a request. The block picks a winner round-robin, latches its frame and shifts it MSB-first with chip-select low, then signals completion. It sits between the frame sources (ROM sequencers, register-write engines) and the SPI pins, and replaces any single-source shifter on the link.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- FRAME_W, 60: frame width in bits; the bit counter is sized to hold FRAME_W-1.
- GAP_CYCLES, 4: extra CSB-high cycles between frames, 1..15. Used only with SPI_ARB_GAP_EN.
- SPI_CLK  in  1: the only clock. All registers update on its falling edge, so the slave samples SDI on the rising edge.
- reset  in  1: synchronous, active-high, sampled on the SPI_CLK falling edge.
- req  in  NUM_REQ: level request per requester; held until gnt.
- req_data  in  NUM_REQ*FRAME_W: requester i's frame at [i*FRAME_W +: FRAME_W]; must be stable while req[i]=1.
- gnt  out  NUM_REQ: one-cycle one-hot pulse on the cycle the frame is latched.
- done  out  NUM_REQ: one-cycle one-hot pulse when the winner's last bit has been held for one cycle.
- busy  out  1: high from the grant edge through the done edge.
- grant_id  out  $clog2(NUM_REQ): index of the current or last winner.
- SPI_CSB  out  1: chip select, active low.
- SPI_SDI  out  1: serial data, MSB first.

## Operation
- Reset values: SPI_CSB=1, SPI_SDI=0, gnt=0, done=0, busy=0, grant_id=0, state=IDLE, RR pointer=0, bit counter=0, shift register=0.
- IDLE:
  - CSB=1.
  - If req is nonzero, pick the first set bit searching upward from the RR pointer, wrapping at NUM_REQ.
  - Latch req_data of the winner, pulse gnt[w], set grant_id=w, busy=1.
  - Drive CSB=0 and SDI=frame[FRAME_W-1], load bit counter=FRAME_W-1, go to SHIFT.
- SHIFT:
  - While the counter is nonzero: decrement it and drive SDI=frame[counter-1].
  - When the counter is 0: set CSB=1, pulse done[w], busy=0, RR pointer=(w+1) mod NUM_REQ, go to IDLE. With SPI_ARB_GAP_EN defined, go to GAP instead.
- GAP (macro only): CSB=1; count GAP_CYCLES edges, then go to IDLE.
- Arbitration rules:
  - Requests are evaluated only in IDLE.
  - Requests arriving during SHIFT wait; they are never lost or reordered except by the RR order.
  - A requester that keeps req high after its done loses priority to every other pending requester.
  - Dropping req before gnt withdraws the request. Dropping req after gnt has no effect on the frame in flight.
- Simultaneous events: if req is zero in IDLE, the block stays idle with SDI holding its last value.
- Reset mid-frame: on the reset edge CSB goes high, the frame is aborted, no done is issued, and the RR pointer returns to 0.
- SDI holds the LSB while CSB rises, then holds it until the next grant.

## Timing
- Grant at falling edge k:
  - gnt and CSB low at k.
  - Bit FRAME_W-1 is valid from k, and bit j is valid from edge k+(FRAME_W-1-j).
  - Bit 0 is valid from k+FRAME_W-1.
  - At k+FRAME_W: CSB=1 and done pulses.
- CSB is low for exactly FRAME_W cycles (60 by default).
- Back-to-back frames:
  - Without the macro, the earliest next grant is k+FRAME_W+1, so CSB is high for a minimum of 1 cycle.
  - With the macro, the earliest next grant is k+FRAME_W+1+GAP_CYCLES.
- Request-to-grant latency from an idle link: 0 cycles. A request sampled high at edge k is granted at k.

## Configuration
- SPI_ARB_GAP_EN:
  - Defined: GAP state present; CSB stays high for 1+GAP_CYCLES cycles between frames to satisfy slave deselect time.
  - Undefined: no GAP state and GAP_CYCLES is ignored; the minimum deselect is 1 cycle.

## Structure
- Shared package spi_pkg:
  - State encoding localparams: IDLE=2'd0, SHIFT=2'd1, GAP=2'd2.
  - Default FRAME_W=60.
  - Round-robin pick function: request vector plus pointer in, index out.
- Sub-module spi_frame_shifter holds the shift register, bit counter, SPI_CSB and SPI_SDI.
  - Interface: load/frame in, last_bit out.
  - The arbiter owns the state machine, RR pointer and gnt/done/grant_id.

## Test plan
- Single requester: after reset, req=4'b0001 with frame 60'hAA5_123456789ABC. gnt[0] at edge k; SDI serialises 0xAA5123456789ABC MSB-first over k..k+59; CSB low exactly 60 cycles; done[0] at k+60.
- All requesters: req=4'b1111 held continuously. Grant order is 0,1,2,3,0. Each frame is intact; CSB goes high for 1 cycle between frames without the macro and for 5 cycles with SPI_ARB_GAP_EN and GAP_CYCLES=4.
- Late request: req[2] asserts mid-SHIFT of requester 1. It is granted at the first IDLE edge after done[1]. No SDI glitch and no change to the frame in flight.
- Abort: reset asserted at bit 30 of a frame. CSB=1, SDI=0, busy=0, no done at the next edge. A subsequent req=4'b0010 is granted with pointer 0 and transmits in full.
- Withdrawal and fairness: req[3] raised then dropped before IDLE, so no gnt[3]. req[0] held after its done while req[1]=1, so requester 1 is granted before 0.
- Patterns: frame 60'hFFF_FFFFFFFFFFFF followed by 60'd0 from two requesters. SDI is all-ones for 60 cycles, then all-zeros for 60 cycles; grant_id shows each winner.
